// File: rtl/msrv32_lsu_bus_master.sv
// Load/store bus master: turns one decoded load/store into a req/gnt/rvalid transaction.
// Optional bus-timeout watchdog enabled by defining MSRV32_LSU_TIMEOUT_EN.
module msrv32_lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        mem_wr_req_in,
  input  logic        mem_rd_req_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wmask_out,
  input  logic        dmem_gnt_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  output logic [31:0] load_data_out,
  output logic        lsu_busy_out,
  output logic        lsu_done_out,
  output logic        bus_err_out
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  state_t     state;
  logic [1:0] size_q;
  logic [1:0] off_q;
  logic       uns_q;

  function automatic logic [3:0] store_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Misaligned halves still select lane off[1]; alignment is checked upstream.
  function automatic logic [31:0] load_format(input logic [31:0] rd, input logic [1:0] sz,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00:   return {{24{b[7] & ~uns}}, b};
      2'b01:   return {{16{h[15] & ~uns}}, h};
      default: return rd;
    endcase
  endfunction

`ifdef MSRV32_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign bus_err_out = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      size_q         <= 2'b00;
      off_q          <= 2'b00;
      uns_q          <= 1'b0;
      dmem_req_out   <= 1'b0;
      dmem_we_out    <= 1'b0;
      dmem_addr_out  <= 32'h0;
      dmem_wdata_out <= 32'h0;
      dmem_wmask_out <= 4'b0000;
      load_data_out  <= 32'h0;
      lsu_busy_out   <= 1'b0;
      lsu_done_out   <= 1'b0;
`ifdef MSRV32_LSU_TIMEOUT_EN
      bus_err_out    <= 1'b0;
      cnt            <= '0;
`endif
    end else begin
      lsu_done_out <= 1'b0;
`ifdef MSRV32_LSU_TIMEOUT_EN
      bus_err_out  <= 1'b0;
      cnt          <= (state == REQ || state == RESP) ? cnt + CNT_W'(1) : '0;
`endif
      case (state)
        IDLE: begin
          // Write wins when both requests arrive together.
          if (mem_wr_req_in || mem_rd_req_in) begin
            state          <= REQ;
            lsu_busy_out   <= 1'b1;
            dmem_req_out   <= 1'b1;
            dmem_we_out    <= mem_wr_req_in;
            dmem_addr_out  <= {addr_in[31:2], 2'b00};
            dmem_wdata_out <= store_wdata(load_size_in, store_data_in);
            dmem_wmask_out <= mem_wr_req_in ? store_mask(load_size_in, addr_in[1:0]) : 4'b0000;
            size_q         <= load_size_in;
            off_q          <= addr_in[1:0];
            uns_q          <= load_unsigned_in;
          end
        end
        REQ: begin
          if (dmem_gnt_in) begin
            dmem_req_out <= 1'b0;
            if (dmem_we_out) begin
              state        <= DONE;
              lsu_done_out <= 1'b1;
            end else begin
              state <= RESP;
            end
          end
`ifdef MSRV32_LSU_TIMEOUT_EN
          else if (timeout_hit) begin
            state        <= DONE;
            dmem_req_out <= 1'b0;
            lsu_done_out <= 1'b1;
            bus_err_out  <= 1'b1;
            if (!dmem_we_out) load_data_out <= 32'h0;
          end
`endif
        end
        RESP: begin
          if (dmem_rvalid_in) begin
            state         <= DONE;
            lsu_done_out  <= 1'b1;
            load_data_out <= load_format(dmem_rdata_in, size_q, off_q, uns_q);
          end
`ifdef MSRV32_LSU_TIMEOUT_EN
          else if (timeout_hit) begin
            state         <= DONE;
            lsu_done_out  <= 1'b1;
            bus_err_out   <= 1'b1;
            load_data_out <= 32'h0;
          end
`endif
        end
        default: begin
          state        <= IDLE;
          lsu_busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_lsu_bus_master.sv
// Directed self-checking bench for msrv32_lsu_bus_master (timeout case runs when
// MSRV32_LSU_TIMEOUT_EN is defined).
module tb_msrv32_lsu_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req, rd_req, uns, gnt, rvalid;
  logic [1:0]  size;
  logic [31:0] addr, sdata, rdata;
  logic        req, we, busy, done, err;
  logic [31:0] daddr, wdata, ldata;
  logic [3:0]  mask;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  msrv32_lsu_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk_in(clk), .rst_in(rst),
    .mem_wr_req_in(wr_req), .mem_rd_req_in(rd_req),
    .load_size_in(size), .load_unsigned_in(uns),
    .addr_in(addr), .store_data_in(sdata),
    .dmem_req_out(req), .dmem_we_out(we), .dmem_addr_out(daddr),
    .dmem_wdata_out(wdata), .dmem_wmask_out(mask),
    .dmem_gnt_in(gnt), .dmem_rvalid_in(rvalid), .dmem_rdata_in(rdata),
    .load_data_out(ldata), .lsu_busy_out(busy), .lsu_done_out(done),
    .bus_err_out(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"},  32'(req),  32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"},  32'(err),  32'd0);
  endtask

  // Load with a stray rvalid in the first REQ cycle, grant in the second, rvalid in RESP.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] rd, input logic [31:0] exp);
    rd_req = 1'b1; addr = a; size = sz; uns = u;
    tick();
    rd_req = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    check({tag, "_req"},  32'(req),  32'd1);
    check({tag, "_we"},   32'(we),   32'd0);
    check({tag, "_mask"}, 32'(mask), 32'd0);
    check({tag, "_addr"}, daddr, {a[31:2], 2'b00});
    tick();
    rvalid = 1'b0; gnt = 1'b1;
    check({tag, "_done_early"}, 32'(done), 32'd0);
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = rd;
    check({tag, "_req_drop"}, 32'(req), 32'd0);
    tick();
    rvalid = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_data"}, ldata, exp);
    tick();
    check_idle({tag, "_end"});
    check({tag, "_hold"}, ldata, exp);
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; uns = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    size = 2'b00; addr = 32'h0; sdata = 32'h0; rdata = 32'h0;
    tick(); tick();
    check_idle("rst");
    check("rst_we",    32'(we),   32'd0);
    check("rst_addr",  daddr,     32'd0);
    check("rst_wdata", wdata,     32'd0);
    check("rst_mask",  32'(mask), 32'd0);
    check("rst_ldata", ldata,     32'd0);
    rst = 1'b0;
    tick();
    check_idle("post_rst");

    // SB 0x1003, grant in first REQ cycle
    wr_req = 1'b1; addr = 32'h0000_1003; sdata = 32'hAABB_CCDD; size = 2'b00;
    tick();
    wr_req = 1'b0; gnt = 1'b1;
    check("sb_req",   32'(req),  32'd1);
    check("sb_we",    32'(we),   32'd1);
    check("sb_addr",  daddr,     32'h0000_1000);
    check("sb_mask",  32'(mask), 32'b1000);
    check("sb_wdata", wdata,     32'hDDDD_DDDD);
    check("sb_busy",  32'(busy), 32'd1);
    check("sb_done0", 32'(done), 32'd0);
    tick();
    gnt = 1'b0;
    check("sb_req_drop", 32'(req),  32'd0);
    check("sb_done",     32'(done), 32'd1);
    check("sb_busy2",    32'(busy), 32'd1);
    tick();
    check_idle("sb_end");

    // SH 0x2002, grant delayed to the 4th REQ cycle
    wr_req = 1'b1; addr = 32'h0000_2002; sdata = 32'h0000_1234; size = 2'b01;
    tick();
    wr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gnt = (i == 3);
      check($sformatf("sh_req%0d", i),   32'(req),  32'd1);
      check($sformatf("sh_mask%0d", i),  32'(mask), 32'b1100);
      check($sformatf("sh_wdata%0d", i), wdata,     32'h1234_1234);
      check($sformatf("sh_addr%0d", i),  daddr,     32'h0000_2000);
      check($sformatf("sh_busy%0d", i),  32'(busy), 32'd1);
      check($sformatf("sh_done%0d", i),  32'(done), 32'd0);
      tick();
    end
    gnt = 1'b0;
    check("sh_done", 32'(done), 32'd1);
    check("sh_req_drop", 32'(req), 32'd0);
    tick();
    check_idle("sh_end");

    do_load("lb",  32'h0000_3001, 2'b00, 1'b0, 32'h0000_8000, 32'hFFFF_FF80);
    do_load("lbu", 32'h0000_3001, 2'b00, 1'b1, 32'h0000_8000, 32'h0000_0080);
    do_load("lhu", 32'h0000_3002, 2'b01, 1'b1, 32'hBEEF_0000, 32'h0000_BEEF);
    do_load("lh",  32'h0000_3002, 2'b01, 1'b0, 32'hBEEF_0000, 32'hFFFF_BEEF);
    do_load("lw",  32'h0000_3004, 2'b10, 1'b0, 32'h8765_4321, 32'h8765_4321);
    do_load("lb3", 32'h0000_3003, 2'b00, 1'b0, 32'h7F00_0000, 32'h0000_007F);

    // Simultaneous write/read: write wins; read held high while busy is ignored
    wr_req = 1'b1; rd_req = 1'b1; addr = 32'h0000_4000; sdata = 32'hCAFE_F00D; size = 2'b10;
    tick();
    wr_req = 1'b0; gnt = 1'b1;
    check("both_we",    32'(we),   32'd1);
    check("both_mask",  32'(mask), 32'hF);
    check("both_wdata", wdata,     32'hCAFE_F00D);
    tick();
    gnt = 1'b0;
    check("both_done", 32'(done), 32'd1);
    rd_req = 1'b0;
    tick();
    check_idle("both_end");
    tick();
    check_idle("both_no_read");

    // Reset in RESP; a later rvalid must be ignored
    rd_req = 1'b1; addr = 32'h0000_5000; size = 2'b10; uns = 1'b0;
    tick();
    rd_req = 1'b0; gnt = 1'b1;
    tick();
    gnt = 1'b0; rst = 1'b1;
    check("rr_in_resp_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b0;
    check_idle("rr_rst");
    check("rr_ldata0", ldata, 32'd0);
    rvalid = 1'b1; rdata = 32'h1234_5678;
    tick();
    rvalid = 1'b0;
    check_idle("rr_after");
    check("rr_ldata", ldata, 32'd0);
    tick();
    check("rr_ldata2", ldata, 32'd0);
    check("rr_done2",  32'(done), 32'd0);

`ifdef MSRV32_LSU_TIMEOUT_EN
    // Grant never arrives: error and done pulse together after 4 REQ cycles
    wr_req = 1'b1; addr = 32'h0000_6000; sdata = 32'h1; size = 2'b10;
    tick();
    wr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req%0d", i), 32'(req), 32'd1);
      check($sformatf("to_err%0d", i), 32'(err), 32'd0);
      tick();
    end
    check("to_err",  32'(err),  32'd1);
    check("to_done", 32'(done), 32'd1);
    check("to_req_drop", 32'(req), 32'd0);
    tick();
    check_idle("to_end");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/msrv32_lsu_bus_master.md
Name: msrv32_lsu_bus_master

Overview:
Load/store bus master sitting on the consuming end of the decoder's memory-control outputs (mem_wr_req, load_size, load_unsigned) and the immediate-adder address. It turns one decoded load or store into a request/grant/response transaction on the data-memory bus. It builds byte-lane masks and replicated write data, then returns a formatted load result. It stalls the pipeline while a transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed in REQ+RESP before bus error (used only with MSRV32_LSU_TIMEOUT_EN)

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  synchronous reset, active-high
mem_wr_req_in  input  1  decoded store request (already gated for misalignment/trap)
mem_rd_req_in  input  1  decoded load request
load_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word
load_unsigned_in  input  1  1 = zero-extend load result
addr_in  input  32  effective address
store_data_in  input  32  rs2 value
dmem_req_out  output  1  bus request
dmem_we_out  output  1  1 = write
dmem_addr_out  output  32  {addr[31:2],2'b00}
dmem_wdata_out  output  32  lane-replicated store data
dmem_wmask_out  output  4  byte enables (0000 on reads)
dmem_gnt_in  input  1  bus accepted request this cycle
dmem_rvalid_in  input  1  read data valid
dmem_rdata_in  input  32  read word
load_data_out  output  32  formatted load result, held until next load completes
lsu_busy_out  output  1  stall: state != IDLE
lsu_done_out  output  1  one-cycle completion pulse
bus_err_out  output  1  one-cycle timeout pulse

Behaviour:
- Reset: state IDLE; every output 0, including load_data_out; counter 0.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If mem_wr_req_in or mem_rd_req_in is high, capture addr, size, unsigned and store data, compute mask/wdata, and go to REQ next cycle.
  - If both are high, the write wins and the read is dropped.
- REQ:
  - dmem_req_out=1; addr, we, wdata and mask stay stable until grant.
  - On dmem_gnt_in: a write goes to DONE; a read goes to RESP. dmem_req_out drops the cycle after the grant.
- RESP:
  - Wait for dmem_rvalid_in, then register the formatted data into load_data_out and go to DONE.
  - rvalid may arrive no earlier than the cycle after the grant. rvalid seen in IDLE, REQ or DONE is ignored.
- DONE: lsu_done_out=1 for exactly one cycle, then return to IDLE.
- Requests arriving in any state other than IDLE are ignored; the pipeline must hold via lsu_busy_out.
- Minimum latency (grant in the first REQ cycle):
  - Store: capture at cycle 0, req cycle 1, done cycle 2.
  - Load: additionally waits for rvalid in RESP; with rvalid at cycle 2, done is cycle 3.
- Write mask:
  - Byte: 0001<<addr[1:0].
  - Half: 0011<<{addr[1],1'b0}.
  - Word: 1111.
- Write data:
  - Byte: {4{d[7:0]}}.
  - Half: {2{d[15:0]}}.
  - Word: d.
- Load format:
  - Byte: rdata lane addr[1:0].
  - Half: lane addr[1].
  - Sign-extend when load_unsigned=0, else zero-extend.
- Misalignment is the decoder's responsibility; a misaligned half at addr[0]=1 still uses lane addr[1] with no error.
- Reset asserted mid-transaction: next state IDLE, req dropped, no done pulse; later rvalid/gnt ignored.

Optional Feature:
MSRV32_LSU_TIMEOUT_EN
- Defined:
  - Counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - On reaching TIMEOUT_CYCLES, go to DONE with bus_err_out=1 and lsu_done_out=1 in the same cycle, and dmem_req_out dropped.
  - A timed-out load sets load_data_out=0.
- Undefined: no counter; bus_err_out tied 0; the FSM waits indefinitely.

Test Plan:
- SB, addr 0x1003, data 0xAABBCCDD, gnt in first REQ cycle -> dmem_addr 0x1000, mask 1000, wdata 0xDDDDDDDD, req high 1 cycle, done pulse at cycle 2.
- SH, addr 0x2002, data 0x00001234, gnt delayed 3 cycles -> mask 1100, wdata 0x12341234 held stable for all 4 REQ cycles, busy high throughout.
- LB signed, addr 0x3001, rdata 0x00008000 -> load_data_out 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x3002, rdata 0xBEEF0000 -> 0x0000BEEF.
- Simultaneous wr/rd request in IDLE -> write only (we=1), read never issued; a new request during busy is ignored.
- Reset asserted in RESP, then rvalid arrives -> outputs 0, no done pulse, load_data_out stays 0.
- With MSRV32_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, gnt never asserted -> bus_err_out and lsu_done_out pulse together after 4 REQ cycles, return to IDLE.
